// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues one instruction-memory request at a time and presents the word to decode.
// Optional fetch timeout with a sticky error flag is compiled in when FETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        valid_reg, valid_next;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= 32'h0000_0000;
      valid_reg <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
`ifdef FETCH_TIMEOUT_EN
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
`ifdef FETCH_TIMEOUT_EN
    cnt_next   = cnt_reg;
    err_next   = err_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        // Read data seen here belongs to an abandoned request and is dropped.
        if (imem_gnt) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_next = imem_rdata;
          valid_next = 1'b1;
          state_next = S_HOLD;
`ifdef FETCH_TIMEOUT_EN
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          // Substitute a nop so the pipeline keeps moving; the flag records the loss.
          instr_next = 32'h0000_0000;
          valid_next = 1'b1;
          err_next   = 1'b1;
          cnt_next   = '0;
          state_next = S_HOLD;
        end else begin
          cnt_next   = cnt_reg + 1'b1;
`endif
        end
      end
      S_HOLD: begin
        if (!stall) begin
          valid_next = 1'b0;
          pc_next    = branch_taken ? (pc_plus4 + (branch_offset << 2)) : pc_plus4;
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign imem_req    = (state_reg == S_FETCH);
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign pc_plus4    = pc_reg + 32'd4;
  assign instr       = instr_reg;
  assign opcode      = instr_reg[31:26];
  assign instr_valid = valid_reg;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_reg;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed cases plus randomized fetch/stall/branch traffic.
// Timeout expectations follow FETCH_TIMEOUT_EN.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC    = 32'h0000_0040;
  localparam int          TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a request, checks its address, then grants it for one cycle.
  task automatic issue_gnt(input string tag, input int gnt_dly, output int req_cyc);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, exp_pc);
    req_cyc = cyc;
    repeat (gnt_dly) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      @(negedge clk);
      check({tag, "_req_held"}, {31'b0, imem_req}, 32'd1);
    end
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    check({tag, "_req_drop"}, {31'b0, imem_req}, 32'd0);
  endtask

  task automatic check_hold(input string tag, input logic [31:0] word);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    check({tag, "_instr"}, instr, word);
    check({tag, "_opcode"}, {26'b0, opcode}, word >> 26);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_pc4"}, pc_plus4, exp_pc + 32'd4);
    check({tag, "_err"}, {31'b0, fetch_err}, {31'b0, exp_err});
  endtask

  task automatic do_fetch(input string tag, input int gnt_dly, input int rv_dly,
                          input logic [31:0] word, output int req_cyc);
    issue_gnt(tag, gnt_dly, req_cyc);
    repeat (rv_dly) @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    check_hold(tag, word);
    $display("fetch %s addr=0x%08h word=0x%08h", tag, exp_pc, word);
  endtask

  // Stalls for stall_n cycles (branch inputs randomized and must be ignored), then consumes.
  task automatic consume(input string tag, input int stall_n, input logic taken,
                         input logic [31:0] off, input logic [31:0] word);
    stall = 1'b1;
    repeat (stall_n) begin
      branch_taken  = 1'($urandom_range(0, 1));
      branch_offset = $urandom;
      @(negedge clk);
      check({tag, "_st_instr"}, instr, word);
      check({tag, "_st_pc"}, pc, exp_pc);
      check({tag, "_st_valid"}, {31'b0, instr_valid}, 32'd1);
      check({tag, "_st_req"}, {31'b0, imem_req}, 32'd0);
    end
    stall         = 1'b0;
    branch_taken  = taken;
    branch_offset = off;
    @(negedge clk);
    stall         = 1'b1;
    branch_taken  = 1'($urandom_range(0, 1));
    branch_offset = $urandom;
    check({tag, "_consumed"}, {31'b0, instr_valid}, 32'd0);
    exp_pc = taken ? exp_pc + 32'd4 + off * 32'd4 : exp_pc + 32'd4;
    $display("consume %s stall=%0d taken=%0b off=0x%08h next=0x%08h", tag, stall_n, taken, off, exp_pc);
  endtask

  initial begin
    int          rc;
    int          prev_rc;
    logic [31:0] w;
    logic [31:0] off;

    exp_pc  = RESET_PC;
    exp_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err", {31'b0, fetch_err}, 32'd0);

    // First fetch after reset release.
    rst_n = 1'b1;
    do_fetch("t1", 0, 0, 32'h8C22_0004, rc);
    check("t1_opcode_lw", {26'b0, opcode}, 32'h23);
    consume("t1", 0, 1'b0, 32'h0, 32'h8C22_0004);
    prev_rc = rc;

    // Back-to-back best case: one request every three cycles.
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      do_fetch("t2", 0, 0, w, rc);
      check("t2_spacing", rc - prev_rc, 32'd3);
      prev_rc = rc;
      consume("t2", 0, 1'b0, 32'h0, w);
    end

    // Four stall cycles in HOLD.
    w = $urandom;
    do_fetch("t3", 1, 1, w, rc);
    consume("t3", 4, 1'b0, 32'h0, w);

    // Branch to 0x100, then backward branch by -2 words.
    off = (32'h100 - exp_pc - 32'd4) >> 2;
    w = $urandom;
    do_fetch("t4a", 0, 0, w, rc);
    consume("t4a", 0, 1'b1, off, w);
    w = $urandom;
    do_fetch("t4b", 0, 0, w, rc);
    check("t4_pc100", pc, 32'h100);
    consume("t4b", 0, 1'b1, 32'hFFFF_FFFE, w);
    check("t4_target", imem_addr, 32'hFC);

    // PC wraps from the top of the address space.
    w = $urandom;
    do_fetch("t5a", 0, 0, w, rc);
    consume("t5a", 0, 1'b1, (32'hFFFF_FFFC - exp_pc - 32'd4) >> 2, w);
    w = $urandom;
    do_fetch("t5b", 0, 0, w, rc);
    check("t5_pc_top", pc, 32'hFFFF_FFFC);
    consume("t5b", 0, 1'b0, 32'h0, w);
    check("t5_wrap", imem_addr, 32'h0);

    // Random traffic.
    for (int i = 0; i < 12; i++) begin
      w   = $urandom;
      off = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128;
      do_fetch("rnd", $urandom_range(0, 3), $urandom_range(0, 3), w, rc);
      consume("rnd", $urandom_range(0, 3), 1'($urandom_range(0, 1)), off, w);
    end

    // No read data after the grant.
    issue_gnt("t6to", 0, rc);
`ifdef FETCH_TIMEOUT_EN
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    check("to_not_yet", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    exp_err = 1'b1;
    check_hold("to_fire", 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("to_late_ignored", instr, 32'h0);
    consume("to", 1, 1'b0, 32'h0, 32'h0);
    w = $urandom;
    do_fetch("to_rv_wins", 0, TIMEOUT_CYC - 1, w, rc);
    consume("to_rv_wins", 0, 1'b0, 32'h0, w);
`else
    repeat (20) @(negedge clk);
    check("nto_valid", {31'b0, instr_valid}, 32'd0);
    check("nto_req", {31'b0, imem_req}, 32'd0);
    check("nto_err", {31'b0, fetch_err}, 32'd0);
    w = $urandom;
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_hold("nto_late", w);
    consume("nto", 0, 1'b0, 32'h0, w);
`endif

    // Reset while waiting for read data; a late rvalid must not be captured.
    issue_gnt("t6", 0, rc);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", {31'b0, imem_req}, 32'd0);
    check("t6_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("t6_rst_pc", pc, RESET_PC);
    check("t6_rst_err", {31'b0, fetch_err}, 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0001;
    repeat (2) @(negedge clk);
    imem_rvalid = 1'b0;
    check("t6_no_capture", {31'b0, instr_valid}, 32'd0);
    check("t6_instr", instr, 32'h0);
    exp_pc  = RESET_PC;
    exp_err = 1'b0;
    w = $urandom;
    do_fetch("t6_after", 0, 0, w, rc);
    consume("t6_after", 0, 1'b0, 32'h0, w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
